// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs a RISC-V field bundle (R, I-arith, LW, SW, BR)
// into a 32-bit word and streams the words into instruction memory at
// consecutive byte addresses, honouring memory backpressure.
module rv_instr_encoder #(
  parameter int unsigned              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]        BASE_ADDR = '0,
  parameter int unsigned              DEPTH     = 64,
  localparam int unsigned             CW        = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  input  logic              mem_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [CW-1:0]     word_count,
  output logic              full,
  output logic              err_illegal,
  input  logic              clr_err
);

  typedef enum logic [2:0] {
    CL_R  = 3'd0,
    CL_I  = 3'd1,
    CL_LW = 3'd2,
    CL_SW = 3'd3,
    CL_BR = 3'd4
  } cls_e;

  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [12:0] imm;
  } req_t;

  req_t        req;
  logic [31:0] enc;
  logic        legal;
  logic        accept;
  logic        wr_done;
  logic [CW:0] pend_cnt;

  assign req = '{cls: in_class, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                 funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  // Words committed plus the one waiting in the output register; once this
  // reaches DEPTH nothing more may be accepted.
  assign pend_cnt = {1'b0, word_count} + {{CW{1'b0}}, wr_en};
  assign full     = (word_count == CW'(DEPTH));
  assign in_ready = !reset && (pend_cnt < (CW+1)'(DEPTH)) && (!wr_en || !mem_busy);
  assign accept   = in_valid && in_ready;
  assign wr_done  = wr_en && !mem_busy;

  // Format assembly; unknown classes and odd branch offsets are flagged illegal.
  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (req.cls)
      CL_R:  enc = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, 7'b0110011};
      CL_I:  enc = {req.imm[11:0], req.rs1, req.funct3, req.rd, 7'b0010011};
      CL_LW: enc = {req.imm[11:0], req.rs1, req.funct3, req.rd, 7'b0000011};
      CL_SW: enc = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], 7'b0100011};
      CL_BR: begin
        enc   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], 7'b1100011};
        legal = !req.imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Output register and write pointer; a new legal word can replace one that
  // completes in the same cycle, giving one write per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_data    <= 32'h0;
      wr_addr    <= BASE_ADDR;
      word_count <= '0;
    end else begin
      if (wr_done) begin
        wr_addr    <= wr_addr + ADDR_W'(4);
        word_count <= word_count + CW'(1);
      end
      if (accept && legal) begin
        wr_en   <= 1'b1;
        wr_data <= enc;
      end else if (wr_done) begin
        wr_en   <= 1'b0;
      end
    end
  end

  // Sticky illegal flag; a fresh illegal bundle beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)
      err_illegal <= 1'b0;
    else if (accept && !legal)
      err_illegal <= 1'b1;
    else if (clr_err)
      err_illegal <= 1'b0;
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder (DEPTH=4 so the full limit is reachable).
module tb_rv_instr_encoder;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [12:0]       in_imm;
  logic              mem_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [CW-1:0]     word_count;
  logic              full;
  logic              err_illegal;
  logic              clr_err;

  int errors = 0;
  int checks = 0;

  rv_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_busy(mem_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .full(full), .err_illegal(err_illegal),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [12:0] imm);
    in_valid = v; in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; mem_busy = 0; clr_err = 0; reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; mem_busy = 0; clr_err = 0; reset = 1;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    checks++;
    if (wr_en !== 1'b0 || wr_data !== 32'h0 || wr_addr !== 32'h0 || word_count !== 3'd0 ||
        full !== 1'b0 || err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got en=%b data=%h addr=%h cnt=%0d full=%b err=%b exp all zero",
               wr_en, wr_data, wr_addr, word_count, full, err_illegal);
    end
    reset = 0;
    #1;
  endtask

  task automatic test_r_type();
    do_reset();
    drive(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL r_ready got=%b exp=1", in_ready); end
    tick();
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 32'h002081B3 || wr_addr !== 32'h0) begin
      errors++;
      $display("FAIL r_write got en=%b data=%h addr=%h exp en=1 data=002081b3 addr=0",
               wr_en, wr_data, wr_addr);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0 || word_count !== 3'd1 || wr_addr !== 32'h4) begin
      errors++;
      $display("FAIL r_done got en=%b cnt=%0d addr=%h exp en=0 cnt=1 addr=4",
               wr_en, word_count, wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8);
    tick();
    drive(1, 3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 13'd12);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 32'h00812283 || wr_addr !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_lw got en=%b data=%h addr=%h rdy=%b exp 1 00812283 0 1",
               wr_en, wr_data, wr_addr, in_ready);
    end
    tick();
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 32'h00512623 || wr_addr !== 32'h4 || word_count !== 3'd1) begin
      errors++;
      $display("FAIL b2b_sw got en=%b data=%h addr=%h cnt=%0d exp 1 00512623 4 1",
               wr_en, wr_data, wr_addr, word_count);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0 || word_count !== 3'd2 || wr_addr !== 32'h8) begin
      errors++;
      $display("FAIL b2b_done got en=%b cnt=%0d addr=%h exp 0 2 8", wr_en, word_count, wr_addr);
    end
  endtask

  task automatic test_branch_illegal();
    do_reset();
    drive(1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 32'hFE208CE3) begin
      errors++;
      $display("FAIL br_enc got en=%b data=%h exp 1 fe208ce3", wr_en, wr_data);
    end
    // Odd branch offset: consumed, no write, error raised.
    drive(1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0005);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL br_bad_ready got=%b exp=1", in_ready); end
    tick();
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    checks++;
    if (wr_en !== 1'b0 || err_illegal !== 1'b1 || word_count !== 3'd1 || wr_addr !== 32'h4) begin
      errors++;
      $display("FAIL br_illegal got en=%b err=%b cnt=%0d addr=%h exp 0 1 1 4",
               wr_en, err_illegal, word_count, wr_addr);
    end
    clr_err = 1;
    tick();
    clr_err = 0;
    checks++;
    if (err_illegal !== 1'b0) begin errors++; $display("FAIL clr_err got=%b exp=0", err_illegal); end
    // Illegal class together with clear: set wins.
    clr_err = 1;
    drive(1, 3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0);
    tick();
    clr_err = 0;
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    checks++;
    if (err_illegal !== 1'b1 || wr_en !== 1'b0 || word_count !== 3'd1) begin
      errors++;
      $display("FAIL set_wins got err=%b en=%b cnt=%0d exp 1 0 1", err_illegal, wr_en, word_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    tick();
    mem_busy = 1;
    drive(1, 3'd1, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 13'd1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 32'h002081B3 || wr_addr !== 32'h0 ||
          in_ready !== 1'b0 || word_count !== 3'd0) begin
        errors++;
        $display("FAIL busy_hold[%0d] got en=%b data=%h addr=%h rdy=%b cnt=%0d exp 1 002081b3 0 0 0",
                 i, wr_en, wr_data, wr_addr, in_ready, word_count);
      end
      tick();
    end
    mem_busy = 0;
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    tick();
    tick();
    checks++;
    if (wr_en !== 1'b0 || word_count !== 3'd1 || wr_addr !== 32'h4) begin
      errors++;
      $display("FAIL busy_release got en=%b cnt=%0d addr=%h exp 0 1 4", wr_en, word_count, wr_addr);
    end
  endtask

  task automatic test_full_and_reset();
    logic [31:0] exp_data [4];
    int k;
    int nw;
    exp_data[0] = 32'h00108113; exp_data[1] = 32'h00208113;
    exp_data[2] = 32'h00308113; exp_data[3] = 32'h00408113;
    do_reset();
    k = 1; nw = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (k <= 6) drive(1, 3'd1, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 13'(k));
      else        drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
      if (wr_en && !mem_busy) begin
        checks++;
        if (nw >= 4 || wr_addr !== 32'(4*nw) || wr_data !== exp_data[nw & 3]) begin
          errors++;
          $display("FAIL full_write[%0d] got addr=%h data=%h exp addr=%h data=%h",
                   nw, wr_addr, wr_data, 32'(4*nw), exp_data[nw & 3]);
        end
        nw++;
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    checks++;
    if (nw !== 4) begin errors++; $display("FAIL full_count got=%0d writes exp=4", nw); end
    drive(1, 3'd1, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 13'd9);
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || word_count !== 3'd4 || wr_addr !== 32'h10 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL full_state got full=%b rdy=%b cnt=%0d addr=%h en=%b exp 1 0 4 10 0",
               full, in_ready, word_count, wr_addr, wr_en);
    end
    // Reset while a word is stuck behind backpressure.
    do_reset();
    drive(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    tick();
    mem_busy = 1;
    drive(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    tick();
    reset = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    tick();
    reset = 0;
    mem_busy = 0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || word_count !== 3'd0 || wr_addr !== 32'h0 || full !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got en=%b cnt=%0d addr=%h full=%b exp 0 0 0 0",
               wr_en, word_count, wr_addr, full);
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; mem_busy = 0; clr_err = 0;
    in_class = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_funct3 = 0; in_funct7 = 0; in_imm = 0;
    test_reset();
    test_r_type();
    test_back_to_back();
    test_branch_illegal();
    test_backpressure();
    test_full_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the main opcode decoder: takes an instruction class plus field values over a valid/ready handshake and assembles the 32-bit RISC-V word (R, I-arith, LW, SW, BR formats).
- Writes each word sequentially into instruction memory through a write port with backpressure.
- Used by the bench and boot loader to program the core's instruction memory before execution.

Parameters:
- ADDR_W, 32, width of the byte address on wr_addr.
- BASE_ADDR, 0, byte address of the first word written after reset.
- DEPTH, 64, maximum number of words written before the encoder reports full.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle on the in_* inputs is valid.
- in_ready  out  1  encoder accepts the bundle this cycle.
- in_class  in  3  0=R, 1=I-arith, 2=LW, 3=SW, 4=BR, 5..7 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R only).
- in_imm  in  13  signed immediate. I/LW/SW use [11:0]; BR uses [12:1], and [0] must be 0.
- mem_busy  in  1  memory cannot take a write this cycle.
- wr_en  out  1  write request.
- wr_addr  out  ADDR_W  byte address of the word.
- wr_data  out  32  encoded instruction.
- word_count  out  $clog2(DEPTH+1)  number of words written (write handshakes completed).
- full  out  1  word_count == DEPTH.
- err_illegal  out  1  sticky; an illegal bundle was consumed.
- clr_err  in  1  clears err_illegal.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, wr_en=0, wr_data=0, wr_addr=BASE_ADDR, word_count=0, full=0, err_illegal=0. An in-flight word is discarded on reset.
- Accept condition: in_valid && in_ready at a rising edge.
- in_ready = !reset && !full && (!wr_en || !mem_busy), with full counting the pending word: in_ready is 0 when word_count + wr_en == DEPTH.
- Output register:
  - A legal accepted bundle loads wr_data and sets wr_en=1 on the next cycle (latency 1).
  - wr_en, wr_data and wr_addr are held stable while mem_busy=1.
- Write handshake: wr_en && !mem_busy.
  - On completion, wr_addr += 4 and word_count += 1.
  - If no new bundle is accepted in the same cycle, wr_en drops. If one is, wr_en stays 1 with the new data (back-to-back, one word per cycle).
- Encodings, with opcode in [6:0]:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}.
  - I: {imm[11:0], rs1, funct3, rd, 0010011}.
  - LW: {imm[11:0], rs1, funct3, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - BR: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
  - Fields not used by a format are ignored.
- Illegal bundle (class 5..7, or BR with imm[0]=1):
  - Still consumed (in_ready unaffected).
  - No write is produced; wr_addr and word_count are unchanged.
  - err_illegal=1 from the next cycle.
- err_illegal clears on clr_err. If clr_err and a new illegal accept occur in the same cycle, the set wins.
- Full:
  - Once DEPTH words have completed, full=1 and in_ready=0 permanently until reset.
  - wr_addr stops at BASE_ADDR + 4*DEPTH; it does not wrap.
- Address arithmetic is modulo 2^ADDR_W.

Test Plan:
- After reset, class 0 with rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> one cycle later wr_en=1, wr_data=0x002081B3, wr_addr=0; word_count=1 after the handshake.
- LW rd=5, rs1=2, funct3=2, imm=8, then SW rs2=5, rs1=2, funct3=2, imm=12, back-to-back with mem_busy=0 -> consecutive writes 0x00812283 @0 and 0x00512623 @4, in_ready held at 1.
- BR rs1=1, rs2=2, funct3=0, imm=-8 (13'h1FF8) -> wr_data=0xFE208CE3. Then BR with imm=13'h0005 -> no write, err_illegal=1 next cycle; clr_err -> 0.
- mem_busy=1 for 3 cycles with a word pending -> wr_en, wr_data and wr_addr stable, in_ready=0. On release, one write only, word_count increments by exactly 1.
- DEPTH=4, stream 6 legal bundles -> exactly 4 writes at 0, 4, 8, 12; full=1 and in_ready=0 afterward. Reset asserted mid-pending write -> wr_en=0, word_count=0, wr_addr=0 next cycle.
